// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the single-cycle MIPS core.
//
// Holds the program counter. Fetches one word from instruction memory over a
// req/ack handshake and presents it as `instruction` until the core retires it
// with `advance`. On retirement the next PC is computed from the decoder's
// branch/jump controls and the datapath flags. Then the next fetch starts.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   imem_addr/req/ack/rdata  instruction-memory handshake (addr == pc)
//   instruction, instr_valid held instruction and its valid flag
//   pc, pc_plus4          address of held instruction and its link value
//   advance               core retires the held instruction this cycle
//   is_jump, pc_select, zero_branch, need_zero, status_branch, need_st_Z
//                         branch/jump controls from the decoder
//   alu_zero, st_Z        datapath flags used by conditional branches
//   reg_rs, mem_target    register / memory jump targets
//   fault                 misaligned-target fault
//
// Configuration macro: FETCH_MISALIGN_TRAP_EN
//   defined   - a misaligned next PC is loaded into pc and the unit parks in
//               FAULT until reset.
//   undefined - next PC bits [1:0] are forced to 00. FAULT is unreachable and
//               fault stays 0.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        advance,
    input  logic        is_jump,
    input  logic [1:0]  pc_select,
    input  logic        zero_branch,
    input  logic        need_zero,
    input  logic        status_branch,
    input  logic        need_st_Z,
    input  logic        alu_zero,
    input  logic        st_Z,
    input  logic [31:0] reg_rs,
    input  logic [31:0] mem_target,
    output logic        fault
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_FAULT} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        req_q;
    logic        valid_q;
    logic        fault_q;

    logic        take;
    logic [31:0] branch_off;
    logic [31:0] target;
    logic [31:0] next_raw;
    logic [31:0] pc_d;
    logic        misaligned;

    assign pc_plus4   = pc_q + 32'd4;
    // Word offset: sign-extend imm16 and scale it by 4 in one concatenation.
    assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    always_comb begin
        take = is_jump
             | (zero_branch   & (alu_zero == need_zero))
             | (status_branch & (st_Z     == need_st_Z));
        case (pc_select)
            2'b00:   target = pc_plus4 + branch_off;
            2'b01:   target = {pc_plus4[31:28], instr_q[25:0], 2'b00};
            2'b10:   target = reg_rs;
            default: target = mem_target;
        endcase
        next_raw = take ? target : pc_plus4;
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign pc_d       = next_raw;
    assign misaligned = |next_raw[1:0];
`else
    // Silently realign. Only register and memory targets can be misaligned.
    assign pc_d       = {next_raw[31:2], 2'b00};
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (advance) begin
                        pc_q    <= pc_d;
                        valid_q <= 1'b0;
                        if (misaligned) begin
                            fault_q <= 1'b1;
                            state_q <= S_FAULT;
                        end else begin
                            // The refetch is issued with the new pc on the same edge.
                            req_q   <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_FAULT: begin
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign imem_req    = req_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A cycle-level behavioural model derived
// from the fetch/retire rules is compared against the DUT on every negedge.
// Directed scenarios also pin literal expectations. A randomized phase then
// exercises the model against the DUT.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        advance = 1'b0;
    logic        is_jump = 1'b0;
    logic [1:0]  pc_select = 2'b00;
    logic        zero_branch = 1'b0;
    logic        need_zero = 1'b0;
    logic        status_branch = 1'b0;
    logic        need_st_Z = 1'b0;
    logic        alu_zero = 1'b0;
    logic        st_Z = 1'b0;
    logic [31:0] reg_rs = 32'd0;
    logic [31:0] mem_target = 32'd0;
    logic        fault;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instruction(instruction),
        .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .advance(advance), .is_jump(is_jump), .pc_select(pc_select),
        .zero_branch(zero_branch), .need_zero(need_zero),
        .status_branch(status_branch), .need_st_Z(need_st_Z),
        .alu_zero(alu_zero), .st_Z(st_Z), .reg_rs(reg_rs),
        .mem_target(mem_target), .fault(fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_started, m_req, m_valid, m_fault;
    logic [31:0] m_pc, m_instr;

    function automatic logic [31:0] ref_next();
        logic [31:0] p4;
        logic [31:0] np;
        int          off;
        bit          taken;
        p4    = m_pc + 32'd4;
        off   = int'($signed(m_instr[15:0]));
        taken = is_jump
             || (zero_branch   && (alu_zero == need_zero))
             || (status_branch && (st_Z     == need_st_Z));
        if (!taken) np = p4;
        else begin
            case (pc_select)
                2'd0:    np = p4 + 32'(off * 4);
                2'd1:    np = (p4 & 32'hF000_0000) + 32'(m_instr[25:0]) * 32'd4;
                2'd2:    np = reg_rs;
                default: np = mem_target;
            endcase
        end
        return np;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started <= 1'b0; m_req <= 1'b0; m_valid <= 1'b0; m_fault <= 1'b0;
            m_pc <= RPC; m_instr <= 32'd0;
        end else if (m_fault) begin
        end else if (!m_started) begin
            m_started <= 1'b1; m_req <= 1'b1;
        end else if (m_req) begin
            if (imem_ack) begin
                m_instr <= imem_rdata; m_req <= 1'b0; m_valid <= 1'b1;
            end
        end else if (m_valid && advance) begin
            logic [31:0] np;
            np = ref_next();
            m_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            m_pc <= np;
            if (np % 4 != 0) m_fault <= 1'b1;
            else             m_req   <= 1'b1;
`else
            m_pc  <= np - (np % 4);
            m_req <= 1'b1;
`endif
        end
    end

    always @(negedge clk) begin
        chk("imem_addr",   imem_addr,   m_pc);
        chk("pc",          pc,          m_pc);
        chk("pc_plus4",    pc_plus4,    m_pc + 32'd4);
        chk("imem_req",    imem_req,    m_req);
        chk("instr_valid", instr_valid, m_valid);
        chk("instruction", instruction, m_instr);
        chk("fault",       fault,       m_fault);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_ctrl();
        is_jump = 0; pc_select = 0; zero_branch = 0; need_zero = 0;
        status_branch = 0; need_st_Z = 0; alu_zero = 0; st_Z = 0;
        reg_rs = 0; mem_target = 0;
    endtask

    // Entered while REQ is pending. Returns with the word held.
    task automatic fetch(input logic [31:0] word, input int waits);
        imem_ack = 0;
        repeat (waits) tick();
        imem_rdata = word; imem_ack = 1;
        tick();
        imem_ack = 0;
    endtask

    task automatic retire(input logic ij, input logic [1:0] sel, input logic zb,
                          input logic nz, input logic az, input logic [31:0] rs);
        is_jump = ij; pc_select = sel; zero_branch = zb; need_zero = nz;
        alu_zero = az; reg_rs = rs; advance = 1;
        tick();
        advance = 0; clear_ctrl();
    endtask

    int fault_cycles;

    initial begin
        // Reset with ack tied high.
        rst_n = 0; imem_ack = 1; imem_rdata = 32'h2010_FEFE;
        repeat (3) tick();
        chk("rst pc", pc, RPC);
        chk("rst req", imem_req, 0);
        chk("rst valid", instr_valid, 0);
        chk("rst instr", instruction, 0);
        chk("rst fault", fault, 0);
        rst_n = 1;
        tick();
        chk("first req", imem_req, 1);
        chk("first addr", imem_addr, RPC);
        chk("first valid", instr_valid, 0);
        tick();
        chk("first hold valid", instr_valid, 1);
        chk("first hold instr", instruction, 32'h2010_FEFE);
        chk("first hold req", imem_req, 0);
        imem_ack = 0;

        // Sequential advance.
        retire(0, 2'b00, 0, 0, 0, 0);
        chk("seq addr", imem_addr, 32'h0040_0004);
        chk("seq plus4", pc_plus4, 32'h0040_0008);
        chk("seq req", imem_req, 1);

        // bne taken / not taken.
        fetch(32'h0, 0); retire(1, 2'b10, 0, 0, 0, 32'h0040_0010);
        chk("jr to bne", pc, 32'h0040_0010);
        fetch(32'h154B_FFFC, 0); retire(0, 2'b00, 1, 0, 0, 0);
        chk("bne taken", pc, 32'h0040_0004);
        fetch(32'h0, 0); retire(1, 2'b10, 0, 0, 0, 32'h0040_0010);
        fetch(32'h154B_FFFC, 1); retire(0, 2'b00, 1, 0, 1, 0);
        chk("bne not taken", pc, 32'h0040_0014);

        // j and jr.
        fetch(32'h0, 0); retire(1, 2'b10, 0, 0, 0, 32'h0040_0020);
        fetch(32'h0800_0004, 0); retire(1, 2'b01, 0, 0, 0, 0);
        chk("j target", pc, 32'h0000_0010);
        fetch(32'h0, 0); retire(1, 2'b10, 0, 0, 0, 32'h0040_0100);
        chk("jr target", pc, 32'h0040_0100);

        // Three wait states, with a stray advance during REQ.
        advance = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait req", imem_req, 1);
            chk("wait addr", imem_addr, 32'h0040_0100);
        end
        advance = 0;
        imem_rdata = 32'h0000_0008; imem_ack = 1;
        tick(); imem_ack = 0;
        chk("wait done valid", instr_valid, 1);
        chk("wait pc unchanged", pc, 32'h0040_0100);

        // Misaligned register target.
        retire(1, 2'b10, 0, 0, 0, 32'h0040_0102);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("trap fault", fault, 1);
        chk("trap req", imem_req, 0);
        imem_ack = 1; advance = 1;
        tick(); tick();
        imem_ack = 0; advance = 0;
        chk("trap req held", imem_req, 0);
        chk("trap fault held", fault, 1);
        chk("trap pc", pc, 32'h0040_0102);
`else
        chk("realign pc", pc, 32'h0040_0100);
        chk("realign req", imem_req, 1);
        chk("realign fault", fault, 0);
`endif

        // Reset mid-REQ, with an ack arriving during reset.
        rst_n = 0; tick(); rst_n = 1; tick();
        fetch(32'h0, 0); retire(1, 2'b10, 0, 0, 0, 32'h0040_0200);
        chk("pre-reset pc", pc, 32'h0040_0200);
        #2 rst_n = 0;
        #1;
        chk("async rst pc", pc, RPC);
        chk("async rst req", imem_req, 0);
        imem_ack = 1;
        tick();
        chk("ack in reset", instr_valid, 0);
        imem_ack = 0; rst_n = 1;

        // Randomized phase.
        fault_cycles = 0;
        for (int n = 0; n < 4000; n++) begin
            imem_ack      = ($urandom_range(0, 2) != 0);
            imem_rdata    = $urandom;
            advance       = ($urandom_range(0, 1) != 0);
            is_jump       = ($urandom_range(0, 3) == 0);
            pc_select     = 2'($urandom_range(0, 3));
            zero_branch   = ($urandom_range(0, 1) != 0);
            need_zero     = ($urandom_range(0, 1) != 0);
            status_branch = ($urandom_range(0, 1) != 0);
            need_st_Z     = ($urandom_range(0, 1) != 0);
            alu_zero      = ($urandom_range(0, 1) != 0);
            st_Z          = ($urandom_range(0, 1) != 0);
            reg_rs        = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            mem_target    = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            fault_cycles  = m_fault ? fault_cycles + 1 : 0;
            rst_n = !(($urandom_range(0, 299) == 0) || (fault_cycles > 3));
            tick();
        end
        rst_n = 1; advance = 0; imem_ack = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
